mem_to_axi_initiator: RTL



---
 rtl/mem_axi_pkg.sv | 81 ++++++++
 rtl/mem_to_axi_initiator.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: direction enum, AXI response decode constants and default AXI4 struct types.
package mem_axi_pkg;

    typedef enum logic [1:0] {IDLE, RD, WR} dir_e;

    localparam int unsigned RESP_ERR_BIT = 1;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Default channel structs (Addr 32, Data 64, Id 2, User 1) for standalone use.
    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        logic [0:0]  user;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic [0:0]  user;
    } axi_w_chan_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [0:0]  user;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_default_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        axi_b_chan_t b;
        logic        r_valid;
        axi_r_chan_t r;
    } axi_rsp_default_t;

endpackage

// File: rtl/mem_to_axi_initiator.sv
// mem_to_axi_initiator: bridges req/gnt/rvalid memory requests to single-beat AXI4 transactions.
module mem_to_axi_initiator
    import mem_axi_pkg::*;
#(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 64,
    parameter int unsigned          IdWidth        = 2,
    parameter logic [IdWidth-1:0]   AxiId          = '0,
    parameter int unsigned          MaxOutstanding = 4,
    parameter type                  axi_req_t      = axi_req_default_t,
    parameter type                  axi_rsp_t      = axi_rsp_default_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output logic                   busy_o,
    output axi_req_t               axi_req_o,
    input  axi_rsp_t               axi_rsp_i
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [2:0]  Size = 3'($clog2(DataWidth / 8));

    logic [CntW-1:0]      cnt_q, cnt_d;
    dir_e                 dir_q, dir_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                 rvalid_q, rvalid_d, err_q, err_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;
    logic                 not_full, rd_elig, wr_elig, ar_hs, aw_hs, w_hs, aw_fin, w_fin, wr_gnt, rsp_hs;
    logic                 unused_rsp;

    always_comb begin
        // A direction change waits for every outstanding response so one ID stays in order.
        not_full  = cnt_q < CntW'(MaxOutstanding);
        rd_elig   = ~rst_i & mem_req_i & ~mem_we_i & not_full & (dir_q != WR || cnt_q == '0);
        wr_elig   = ~rst_i & mem_req_i & mem_we_i & not_full & (dir_q != RD || cnt_q == '0);
        ar_hs     = rd_elig & axi_rsp_i.ar_ready;
        aw_hs     = wr_elig & ~aw_done_q & axi_rsp_i.aw_ready;
        w_hs      = wr_elig & ~w_done_q & axi_rsp_i.w_ready;
        aw_fin    = aw_done_q | aw_hs;
        w_fin     = w_done_q | w_hs;
        wr_gnt    = wr_elig & aw_fin & w_fin;
        mem_gnt_o = ar_hs | wr_gnt;
        rsp_hs    = axi_rsp_i.r_valid | axi_rsp_i.b_valid;
        cnt_d     = cnt_q + CntW'(mem_gnt_o) - CntW'(rsp_hs);
        dir_d     = mem_gnt_o ? (mem_we_i ? WR : RD) : (cnt_d == '0 ? IDLE : dir_q);
        aw_done_d = aw_fin & ~wr_gnt;
        w_done_d  = w_fin & ~wr_gnt;
        rvalid_d  = rsp_hs;
        rdata_d   = axi_rsp_i.r_valid ? axi_rsp_i.r.data : '0;
        err_d     = axi_rsp_i.r_valid ? axi_rsp_i.r.resp[RESP_ERR_BIT]
                                      : axi_rsp_i.b_valid & axi_rsp_i.b.resp[RESP_ERR_BIT];
        axi_req_o          = '0;
        axi_req_o.aw.id    = AxiId;
        axi_req_o.aw.addr  = mem_addr_i;
        axi_req_o.aw.size  = Size;
        axi_req_o.aw.burst = BURST_INCR;
        axi_req_o.aw_valid = wr_elig & ~aw_done_q;
        axi_req_o.w.data   = mem_wdata_i;
        axi_req_o.w.strb   = mem_strb_i;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = wr_elig & ~w_done_q;
        axi_req_o.b_ready  = 1'b1;
        axi_req_o.ar.id    = AxiId;
        axi_req_o.ar.addr  = mem_addr_i;
        axi_req_o.ar.size  = Size;
        axi_req_o.ar.burst = BURST_INCR;
        axi_req_o.ar_valid = rd_elig;
        axi_req_o.r_ready  = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            dir_q     <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
    assign mem_err_o    = err_q;
    assign busy_o       = cnt_q != '0;
    assign unused_rsp   = ^{axi_rsp_i.b.id, axi_rsp_i.b.user, axi_rsp_i.b.resp[0], axi_rsp_i.r.id,
                            axi_rsp_i.r.resp[0], axi_rsp_i.r.last, axi_rsp_i.r.user};

`ifndef SYNTHESIS
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (axi_rsp_i.r_valid | axi_rsp_i.b_valid) |-> cnt_q != '0);
    a_r_dir: assert property (@(posedge clk_i) disable iff (rst_i) axi_rsp_i.r_valid |-> dir_q == RD);
    a_b_dir: assert property (@(posedge clk_i) disable iff (rst_i) axi_rsp_i.b_valid |-> dir_q == WR);
    a_stable: assert property (@(posedge clk_i) disable iff (rst_i) (mem_req_i && !mem_gnt_o) |=>
        (mem_req_i && $stable(mem_addr_i) && $stable(mem_we_i) && $stable(mem_wdata_i) && $stable(mem_strb_i)));
`endif

endmodule
